sha256_compress_ctrl: RTL and testbench
=======================================

Name: sha256_compress_ctrl

Overview:
Sequencer for the SHA-256 compression round datapath (MOD_COMPRESSOR). It owns the chaining hash H0..H7, drives the round index and K constant, and steps the compressor through 64 rounds per block, stalling when the message-schedule word is not available. After round 63 it folds the working variables a..h into H (mod 2^32) and reports completion with a one-cycle DONE pulse. Multi-block messages use chaining: H is carried from one block to the next unless INIT requests the initial hash values (IV).

Parameters:
ROUNDS, 64, rounds per block; only 64 is supported, parameter kept for bench visibility.
IV, {6a09e667,bb67ae85,3c6ef372,a54ff53a,510e527f,9b05688c,1f83d9ab,5be0cd19}, 256-bit initial hash value, H0 in MSBs.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RESET_N  in  1  reset, asynchronous, active-low.
START  in  1  start one block; sampled only in IDLE.
INIT  in  1  sampled with START; 1 loads IV into H before the block, 0 chains the current H.
ABORT  in  1  synchronous abort; returns to IDLE, H untouched.
W_VALID  in  1  message-schedule word for CMP_I is present on the compressor W input.
W_READY  out  1  word consumed this cycle (W_VALID & state==ROUND).
CMP_EN  out  1  compressor round enable.
CMP_I  out  6  round index.
CMP_K  out  32  K[CMP_I] from the internal FIPS 180-4 ROM (combinational).
CMP_H  out  256  current H0..H7 to the compressor, H0 in [255:224].
WORK_IN  in  256  compressor a..h, a in [255:224].
BUSY  out  1  high from the cycle after accepted START through the DONE cycle.
DONE  out  1  one-cycle pulse; DIGEST is valid from this cycle.
DIGEST  out  256  equals CMP_H.

Behaviour:
- Reset (RESET_N=0, asynchronous): state=IDLE, CMP_I=0, BUSY=0, DONE=0, CMP_EN=0, W_READY=0, H=IV.
- States are IDLE, ROUND, FINAL, DONE_ST.
- IDLE:
  - START=1 and ABORT=0 go to ROUND with CMP_I=0.
  - If INIT=1, H<=IV on the same edge.
  - If ABORT=1, START is ignored.
- ROUND:
  - CMP_EN=W_READY=W_VALID (combinational).
  - Edge with W_VALID=1: if CMP_I==63, go to FINAL (CMP_I stays 63); otherwise CMP_I<=CMP_I+1.
  - W_VALID=0 is a stall: CMP_I holds and CMP_EN=0. Stall length is unbounded.
- Compressor contract:
  - It consumes round CMP_I on an edge with CMP_EN=1.
  - At CMP_I=0 it initialises from CMP_H.
  - Its outputs are registered, so WORK_IN reflects round 63 during the FINAL cycle.
- FINAL (1 cycle): CMP_EN=0. On the edge, Hj<=Hj+WORKj mod 2^32 for each j, the carry is discarded, and the state goes to DONE_ST.
- DONE_ST (1 cycle): DONE=1, BUSY=1, then IDLE on the next edge. START in this cycle is ignored.
- Latency with no stall: START edge to DONE high is 66 cycles (64 ROUND + FINAL + DONE_ST). Each stall cycle adds 1.
- START while BUSY=1 is ignored, not queued.
- ABORT in ROUND, FINAL or DONE_ST:
  - Next state is IDLE and CMP_I=0.
  - H is unchanged, including in FINAL, where ABORT wins over the add.
  - No DONE pulse.
- RESET_N low mid-block: all outputs return to reset values immediately and H=IV.
- CMP_H is stable throughout ROUND, because H changes only at IDLE/START and at FINAL.

Test Plan:
1. Hold RESET_N=0 -> BUSY=0, DONE=0, CMP_EN=0, CMP_I=0, DIGEST=6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19. Release, idle 10 cycles -> no change.
2. Stub compressor with WORK_IN=0, W_VALID=1, START with INIT=1:
   - CMP_EN high exactly 64 cycles and CMP_I steps 0..63.
   - CMP_K=428a2f98 at I=0 and c67178f2 at I=63.
   - DONE pulses once, 66 cycles after the START edge, and DIGEST=IV.
3. Stub WORK_IN=ffffffff in all words, START with INIT=1 -> DIGEST: H0=6a09e666 and H7=5be0cd18 (wrap, no carry). A second START with INIT=0 -> H0=6a09e665.
4. Drop W_VALID for 5 cycles at CMP_I=10 -> CMP_I holds 10, CMP_EN=0 and W_READY=0 during the stall, DONE arrives at cycle 71. A START pulsed during BUSY has no effect.
5. Two abort/reset cases:
   - ABORT at CMP_I=30 -> IDLE next cycle, BUSY=0, no DONE, DIGEST unchanged.
   - RESET_N pulsed low at CMP_I=40 -> immediate reset values, DIGEST=IV.
6. Real MOD_COMPRESSOR with the padded "Hello world!" block, W streamed with W_VALID=1 and INIT=1 -> DIGEST=c0535e4b e2b79ffd 93291305 436bf889 314e4a3f aec05ecf fcbb7df3 1ad9e51a.

Source files
------------

// File: rtl/sha256_compress_ctrl.sv
// -----------------------------------------------------------------------------
// sha256_compress_ctrl
//   Sequencer for the SHA-256 compression round datapath. Holds the chaining
//   hash H0..H7, steps the external compressor through one round per consumed
//   message-schedule word, folds the working variables into H after the last
//   round and flags completion with a one-cycle done pulse.
//
// Ports
//   clk      in   1    clock, rising edge
//   reset_n  in   1    asynchronous active-low reset (H returns to IV)
//   start    in   1    start one block, sampled only in IDLE
//   init     in   1    with start: 1 loads IV into H, 0 chains current H
//   abort    in   1    synchronous abort back to IDLE, H untouched
//   w_valid  in   1    schedule word for cmp_i present at the compressor
//   w_ready  out  1    word consumed this cycle
//   cmp_en   out  1    compressor round enable
//   cmp_i    out  6    round index
//   cmp_k    out  32   round constant K[cmp_i]
//   cmp_h    out  256  current H0..H7, H0 in [255:224]
//   work_in  in   256  compressor working variables a..h, a in [255:224]
//   busy     out  1    block in progress (cycle after start through done)
//   done     out  1    one-cycle completion pulse
//   digest   out  256  current H (valid from the done cycle)
// -----------------------------------------------------------------------------
module sha256_compress_ctrl #(
  parameter int unsigned  ROUNDS = 64,
  parameter logic [255:0] IV     = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19}
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         init,
  input  logic         abort,
  input  logic         w_valid,
  output logic         w_ready,
  output logic         cmp_en,
  output logic [5:0]   cmp_i,
  output logic [31:0]  cmp_k,
  output logic [255:0] cmp_h,
  input  logic [255:0] work_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t       state_r, state_s;
  logic [5:0]   idx_r, idx_s;
  logic [255:0] h_r, h_s;
  logic         w_ready_s;

  // FIPS 180-4 round constants
  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    case (idx)
      6'd0:  return 32'h428a2f98;  6'd1:  return 32'h71374491;
      6'd2:  return 32'hb5c0fbcf;  6'd3:  return 32'he9b5dba5;
      6'd4:  return 32'h3956c25b;  6'd5:  return 32'h59f111f1;
      6'd6:  return 32'h923f82a4;  6'd7:  return 32'hab1c5ed5;
      6'd8:  return 32'hd807aa98;  6'd9:  return 32'h12835b01;
      6'd10: return 32'h243185be;  6'd11: return 32'h550c7dc3;
      6'd12: return 32'h72be5d74;  6'd13: return 32'h80deb1fe;
      6'd14: return 32'h9bdc06a7;  6'd15: return 32'hc19bf174;
      6'd16: return 32'he49b69c1;  6'd17: return 32'hefbe4786;
      6'd18: return 32'h0fc19dc6;  6'd19: return 32'h240ca1cc;
      6'd20: return 32'h2de92c6f;  6'd21: return 32'h4a7484aa;
      6'd22: return 32'h5cb0a9dc;  6'd23: return 32'h76f988da;
      6'd24: return 32'h983e5152;  6'd25: return 32'ha831c66d;
      6'd26: return 32'hb00327c8;  6'd27: return 32'hbf597fc7;
      6'd28: return 32'hc6e00bf3;  6'd29: return 32'hd5a79147;
      6'd30: return 32'h06ca6351;  6'd31: return 32'h14292967;
      6'd32: return 32'h27b70a85;  6'd33: return 32'h2e1b2138;
      6'd34: return 32'h4d2c6dfc;  6'd35: return 32'h53380d13;
      6'd36: return 32'h650a7354;  6'd37: return 32'h766a0abb;
      6'd38: return 32'h81c2c92e;  6'd39: return 32'h92722c85;
      6'd40: return 32'ha2bfe8a1;  6'd41: return 32'ha81a664b;
      6'd42: return 32'hc24b8b70;  6'd43: return 32'hc76c51a3;
      6'd44: return 32'hd192e819;  6'd45: return 32'hd6990624;
      6'd46: return 32'hf40e3585;  6'd47: return 32'h106aa070;
      6'd48: return 32'h19a4c116;  6'd49: return 32'h1e376c08;
      6'd50: return 32'h2748774c;  6'd51: return 32'h34b0bcb5;
      6'd52: return 32'h391c0cb3;  6'd53: return 32'h4ed8aa4a;
      6'd54: return 32'h5b9cca4f;  6'd55: return 32'h682e6ff3;
      6'd56: return 32'h748f82ee;  6'd57: return 32'h78a5636f;
      6'd58: return 32'h84c87814;  6'd59: return 32'h8cc70208;
      6'd60: return 32'h90befffa;  6'd61: return 32'ha4506ceb;
      6'd62: return 32'hbef9a3f7;  6'd63: return 32'hc67178f2;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Word-wise mod 2^32 add; carries never cross word boundaries
  function automatic logic [255:0] fold_words(input logic [255:0] h, input logic [255:0] w);
    logic [255:0] r;
    r = 256'd0;
    for (int j = 0; j < 8; j++) begin
      r[32*j +: 32] = h[32*j +: 32] + w[32*j +: 32];
    end
    return r;
  endfunction

  // Next-state, round index and chaining-hash update
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    h_s       = h_r;
    w_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        idx_s = 6'd0;
        if (start && !abort) begin
          state_s = ST_ROUND;
          if (init) begin
            h_s = IV;
          end else begin
            h_s = h_r;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ROUND: begin
        w_ready_s = w_valid;
        if (abort) begin
          state_s = ST_IDLE;
          idx_s   = 6'd0;
        end else if (w_valid) begin
          if (idx_r == LAST_IDX) begin
            state_s = ST_FINAL;
          end else begin
            idx_s = idx_r + 6'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      ST_FINAL: begin
        // Abort takes priority over the fold so H is left untouched
        if (abort) begin
          state_s = ST_IDLE;
          idx_s   = 6'd0;
        end else begin
          h_s     = fold_words(h_r, work_in);
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        idx_s   = 6'd0;
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = 6'd0;
      end
    endcase
  end

  // State, round index and chaining-hash registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      idx_r   <= 6'd0;
      h_r     <= IV;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      h_r     <= h_s;
    end
  end

  assign w_ready = w_ready_s;
  assign cmp_en  = w_ready_s;
  assign cmp_i   = idx_r;
  assign cmp_k   = k_rom(idx_r);
  assign cmp_h   = h_r;
  assign digest  = h_r;
  assign busy    = (state_r != ST_IDLE);
  assign done    = (state_r == ST_DONE);

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sha256_compress_ctrl
//   Directed bench for sha256_compress_ctrl. A behavioural compressor (or a
//   constant stub) answers the controller; expected digests are queued when a
//   block is started and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_sha256_compress_ctrl;

  localparam logic [255:0] IV_C = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV_M1 = {32'h6a09e666, 32'hbb67ae84, 32'h3c6ef371, 32'ha54ff539,
                                    32'h510e527e, 32'h9b05688b, 32'h1f83d9aa, 32'h5be0cd18};
  localparam logic [255:0] IV_M2 = {32'h6a09e665, 32'hbb67ae83, 32'h3c6ef370, 32'ha54ff538,
                                    32'h510e527d, 32'h9b05688a, 32'h1f83d9a9, 32'h5be0cd17};
  localparam logic [255:0] HELLO_C = {32'hc0535e4b, 32'he2b79ffd, 32'h93291305, 32'h436bf889,
                                      32'h314e4a3f, 32'haec05ecf, 32'hfcbb7df3, 32'h1ad9e51a};

  logic         clk = 1'b0;
  logic         reset_n, start, init, abort, w_valid;
  logic         w_ready, cmp_en, busy, done;
  logic [5:0]   cmp_i;
  logic [31:0]  cmp_k;
  logic [255:0] cmp_h, work_in, digest;

  logic         stub_mode;
  logic [255:0] stub_work;
  logic [255:0] comp_work_r;
  logic [31:0]  w_mem [64];
  logic [255:0] sb_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sha256_compress_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .init    (init),
    .abort   (abort),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .cmp_en  (cmp_en),
    .cmp_i   (cmp_i),
    .cmp_k   (cmp_k),
    .cmp_h   (cmp_h),
    .work_in (work_in),
    .busy    (busy),
    .done    (done),
    .digest  (digest)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Behavioural compressor: registered working variables, seeded from cmp_h at round 0
  always @(posedge clk) begin
    if (cmp_en) begin
      comp_work_r <= sha_round((cmp_i == 6'd0) ? cmp_h : comp_work_r, w_mem[cmp_i], cmp_k);
    end
  end

  assign work_in = stub_mode ? stub_work : comp_work_r;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One block: optional stall window, optional start pulse while busy
  task automatic run_block(input logic ini, input logic [255:0] exp_dig, input int stall_at,
                           input int stall_len, input int exp_lat, input logic poke_start);
    int n, en_cnt, stall_left, idx_exp;
    logic seen_done, idx_ok;
    sb_q.push_back(exp_dig);
    @(negedge clk);
    start = 1'b1; init = ini; w_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; init = 1'b0;
    n = 1; en_cnt = 0; stall_left = stall_len; idx_exp = 0; seen_done = 1'b0; idx_ok = 1'b1;
    while (!seen_done && n < 200) begin
      start = poke_start && (n == 20);
      if (en_cnt == stall_at && stall_left > 0) begin
        w_valid = 1'b0;
        stall_left--;
      end else begin
        w_valid = 1'b1;
      end
      #1;
      if (!w_valid) begin
        check("stall_idx", 256'(cmp_i), 256'(stall_at));
        check("stall_en", 256'(cmp_en), 256'd0);
        check("stall_ready", 256'(w_ready), 256'd0);
      end
      if (cmp_en) begin
        if (cmp_i != 6'(idx_exp)) idx_ok = 1'b0;
        if (cmp_i == 6'd0)  check("k_0", 256'(cmp_k), 256'h428a2f98);
        if (cmp_i == 6'd63) check("k_63", 256'(cmp_k), 256'hc67178f2);
        idx_exp++;
        en_cnt++;
      end
      if (done) begin
        seen_done = 1'b1;
        check("latency", 256'(n), 256'(exp_lat));
        check("sb_nonempty", 256'(sb_q.size() != 0), 256'd1);
        if (sb_q.size() != 0) check("digest", digest, sb_q.pop_front());
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; w_valid = 1'b1;
    check("done_seen", 256'(seen_done), 256'd1);
    check("en_count", 256'(en_cnt), 256'd64);
    check("idx_seq", 256'(idx_ok), 256'd1);
    #1;
    check("done_pulse_end", 256'(done), 256'd0);
    check("busy_end", 256'(busy), 256'd0);
  endtask

  // Abort after abort_at consumed rounds (64 lands in the fold cycle)
  task automatic run_abort(input int abort_at, input logic [255:0] exp_dig);
    int n, en_cnt, done_cnt;
    @(negedge clk);
    start = 1'b1; init = 1'b0; w_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; en_cnt = 0;
    while (en_cnt != abort_at && n < 200) begin
      #1;
      if (cmp_en) en_cnt++;
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached", 256'(en_cnt), 256'(abort_at));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 256'(busy), 256'd0);
    check("abort_done", 256'(done), 256'd0);
    check("abort_idx", 256'(cmp_i), 256'd0);
    check("abort_digest", digest, exp_dig);
    done_cnt = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 256'(done_cnt), 256'd0);
  endtask

  initial begin
    logic [31:0] s0, s1;
    int en_cnt;
    reset_n = 1'b0; start = 1'b0; init = 1'b0; abort = 1'b0; w_valid = 1'b1;
    stub_mode = 1'b1; stub_work = 256'd0;

    // "Hello world!" padded block and its message schedule
    w_mem[0] = 32'h48656c6c; w_mem[1] = 32'h6f20776f; w_mem[2] = 32'h726c6421; w_mem[3] = 32'h80000000;
    for (int t = 4; t < 15; t++) w_mem[t] = 32'h0000_0000;
    w_mem[15] = 32'h00000060;
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w_mem[t-15], 7) ^ rotr(w_mem[t-15], 18) ^ (w_mem[t-15] >> 3);
      s1 = rotr(w_mem[t-2], 17) ^ rotr(w_mem[t-2], 19) ^ (w_mem[t-2] >> 10);
      w_mem[t] = w_mem[t-16] + s0 + w_mem[t-7] + s1;
    end

    // Reset state
    #23;
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_en", 256'(cmp_en), 256'd0);
    check("rst_idx", 256'(cmp_i), 256'd0);
    check("rst_digest", digest, IV_C);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_busy", 256'(busy), 256'd0);
    check("idle_en", 256'(cmp_en), 256'd0);
    check("idle_digest", digest, IV_C);

    // Zero work, IV load; then stalled block with a stray start while busy
    run_block(1'b1, IV_C, -1, 0, 66, 1'b0);
    run_block(1'b1, IV_C, 10, 5, 71, 1'b1);

    // All-ones work: wrap per word, then chaining
    stub_work = {8{32'hffffffff}};
    run_block(1'b1, IV_M1, -1, 0, 66, 1'b0);
    run_block(1'b0, IV_M2, -1, 0, 66, 1'b0);

    // Aborts in ROUND and in the fold cycle leave H alone
    run_abort(30, IV_M2);
    run_abort(64, IV_M2);

    // Asynchronous reset mid-block
    @(negedge clk);
    start = 1'b1; init = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    en_cnt = 0;
    while (cmp_i != 6'd40 && en_cnt < 200) begin
      @(posedge clk); #1;
      en_cnt++;
    end
    check("rst_mid_reached", 256'(cmp_i), 256'd40);
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 256'(busy), 256'd0);
    check("rst_mid_idx", 256'(cmp_i), 256'd0);
    check("rst_mid_en", 256'(cmp_en), 256'd0);
    check("rst_mid_done", 256'(done), 256'd0);
    check("rst_mid_digest", digest, IV_C);
    @(negedge clk);
    reset_n = 1'b1;

    // Real compression of the "Hello world!" block
    stub_mode = 1'b0;
    run_block(1'b1, HELLO_C, -1, 0, 66, 1'b0);

    check("sb_drained", 256'(sb_q.size()), 256'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
